// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational ALU between two requesters,
// with a one-entry issue stage and a one-entry response slot per requester.
module alu_share_arb #(
  parameter int DATA_W  = 32,
  parameter int FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [FUNCT_W-1:0] req0_funct,
  input  logic [DATA_W-1:0]  req0_in1,
  input  logic [DATA_W-1:0]  req0_in2,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [FUNCT_W-1:0] req1_funct,
  input  logic [DATA_W-1:0]  req1_in1,
  input  logic [DATA_W-1:0]  req1_in2,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic [DATA_W-1:0]  resp0_data,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [DATA_W-1:0]  resp1_data,
  output logic [FUNCT_W-1:0] alu_funct,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  input  logic [DATA_W-1:0]  alu_out
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   elig0;
  logic   elig1;
  logic   grant0;
  logic   grant1;

  // One op in flight per requester; the requester not granted last wins ties.
  always_comb begin
    elig0  = req0_valid
           && !(state == BUSY && !owner)
           && (!resp0_valid || resp0_ready);
    elig1  = req1_valid
           && !(state == BUSY && owner)
           && (!resp1_valid || resp1_ready);
    grant0 = elig0 && (!elig1 || last_grant);
    grant1 = elig1 && (!elig0 || !last_grant);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Issue stage: load the granted op, otherwise drop back to IDLE with ALU inputs zeroed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_funct  <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
    end else begin
      unique case (1'b1)
        grant0: begin
          state      <= BUSY;
          owner      <= 1'b0;
          last_grant <= 1'b0;
          alu_funct  <= req0_funct;
          alu_in1    <= req0_in1;
          alu_in2    <= req0_in2;
        end
        grant1: begin
          state      <= BUSY;
          owner      <= 1'b1;
          last_grant <= 1'b1;
          alu_funct  <= req1_funct;
          alu_in1    <= req1_in1;
          alu_in2    <= req1_in2;
        end
        default: begin
          state     <= IDLE;
          alu_funct <= '0;
          alu_in1   <= '0;
          alu_in2   <= '0;
        end
      endcase
    end
  end

  // Response slots: drain on ready, and a capture from the ALU overrides the drain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp0_valid <= 1'b0;
      resp0_data  <= '0;
      resp1_valid <= 1'b0;
      resp1_data  <= '0;
    end else begin
      if (resp0_ready) resp0_valid <= 1'b0;
      if (resp1_ready) resp1_valid <= 1'b0;
      if (state == BUSY && !owner) begin
        resp0_valid <= 1'b1;
        resp0_data  <= alu_out;
      end
      if (state == BUSY && owner) begin
        resp1_valid <= 1'b1;
        resp1_data  <= alu_out;
      end
    end
  end

endmodule
